// File: rtl/ofm_accumulator_pkg.sv
// ============================================================================
// Module      : ofm_accumulator_pkg
// Description : Shared constants and helpers for the OFM accumulator: ceil-log2
//               function, accumulator width derivation, default port widths
//               and the per-layer OFM width table for VGG-16.
//               Optional feature macro used by the slice: OFM_ACC_SAT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ofm_accumulator_pkg;

    localparam int c_PSUM_BIT_DEF  = 24;
    localparam int c_BIAS_BIT_DEF  = 16;
    localparam int c_OFM_BIT_DEF   = 29;
    localparam int c_IN_GROUPS_DEF = 64;

    // OFM width needed by each of the 13 VGG-16 convolution layers.
    localparam int c_VGG16_LAYERS = 13;
    localparam int c_VGG16_OFM_BIT [c_VGG16_LAYERS] =
        '{21, 22, 23, 24, 24, 25, 25, 26, 26, 27, 28, 28, 29};

    // Ceiling log2; clog2(1) = 0.
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

    // Accumulator wide enough that bias + IN_GROUPS partial sums never overflow.
    function automatic int acc_bit(input int psum_bit, input int bias_bit,
                                   input int in_groups);
        return ((psum_bit > bias_bit) ? psum_bit : bias_bit) + clog2(in_groups) + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ofm_sat_clamp.sv
// ============================================================================
// Module      : ofm_sat_clamp
// Description : Combinational ACC_BIT -> OFM_BIT reduction of a signed value.
//               OFM_ACC_SAT_EN defined  : saturate to the OFM_BIT signed range.
//               OFM_ACC_SAT_EN undefined: keep the low OFM_BIT bits (wrap).
//               When ACC_BIT <= OFM_BIT the value is sign-extended.
// Ports       : acc_in  [ACC_BIT-1:0]  signed accumulator value
//               ofm_out [OFM_BIT-1:0]  signed reduced value
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ofm_sat_clamp #(
    parameter int ACC_BIT = 31,
    parameter int OFM_BIT = 29
) (
    input  logic [ACC_BIT-1:0] acc_in,
    output logic [OFM_BIT-1:0] ofm_out
);

    generate
        if (ACC_BIT <= OFM_BIT) begin : g_extend
            assign ofm_out = OFM_BIT'($signed(acc_in));
        end else begin : g_reduce
`ifdef OFM_ACC_SAT_EN
            // The value fits only if every bit from the OFM sign bit upward
            // agrees; otherwise pick the rail matching the true sign.
            logic w_ovf;
            assign w_ovf   = ~((&acc_in[ACC_BIT-1:OFM_BIT-1]) |
                               ~(|acc_in[ACC_BIT-1:OFM_BIT-1]));
            assign ofm_out = w_ovf ? {acc_in[ACC_BIT-1], {(OFM_BIT-1){~acc_in[ACC_BIT-1]}}}
                                   : acc_in[OFM_BIT-1:0];
`else
            // Upper bits are intentionally discarded in wrap mode.
            logic w_unused_hi;
            assign w_unused_hi = ^acc_in[ACC_BIT-1:OFM_BIT];
            assign ofm_out     = acc_in[OFM_BIT-1:0];
`endif
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/ofm_accumulator.sv
// ============================================================================
// Module      : ofm_accumulator
// Description : Accumulates IN_GROUPS signed partial sums plus a fused bias
//               (sampled on the first beat) into one OFM value, clamps it to
//               OFM_BIT and emits it with a one-cycle out_valid pulse.
//               Clamp behaviour selected by macro OFM_ACC_SAT_EN
//               (defined = saturate, undefined = two's-complement wrap).
// Ports       : clk, rst (sync, active-high)
//               in_valid, psum [PSUM_BIT], bias [BIAS_BIT]   - input beat
//               out_valid, OFM [OFM_BIT]                      - result
//               busy                                          - group in progress
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ofm_accumulator
    import ofm_accumulator_pkg::*;
#(
    parameter int PSUM_BIT  = c_PSUM_BIT_DEF,
    parameter int BIAS_BIT  = c_BIAS_BIT_DEF,
    parameter int OFM_BIT   = c_OFM_BIT_DEF,
    parameter int IN_GROUPS = c_IN_GROUPS_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    input  logic [PSUM_BIT-1:0] psum,
    input  logic [BIAS_BIT-1:0] bias,
    output logic                out_valid,
    output logic [OFM_BIT-1:0]  OFM,
    output logic                busy
);

    localparam int                 c_ACC_BIT  = acc_bit(PSUM_BIT, BIAS_BIT, IN_GROUPS);
    localparam int                 c_CNT_W    = (IN_GROUPS > 1) ? clog2(IN_GROUPS) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(IN_GROUPS - 1);

    localparam logic [0:0] c_ST_IDLE  = 1'b0;
    localparam logic [0:0] c_ST_ACCUM = 1'b1;

    logic [0:0]           r_state;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [c_ACC_BIT-1:0] r_acc;
    logic                 r_out_valid;
    logic [OFM_BIT-1:0]   r_ofm;

    logic [c_ACC_BIT-1:0] w_psum_ext;
    logic [c_ACC_BIT-1:0] w_bias_ext;
    logic [c_ACC_BIT-1:0] w_base;
    logic [c_ACC_BIT-1:0] w_sum;
    logic [OFM_BIT-1:0]   w_clamped;
    logic                 w_last;

    assign w_psum_ext = c_ACC_BIT'($signed(psum));
    assign w_bias_ext = c_ACC_BIT'($signed(bias));

    // The first beat of a group starts from the bias instead of the running sum,
    // so the same adder serves both the first and the following beats.
    assign w_base = (r_state == c_ST_IDLE) ? w_bias_ext : r_acc;
    assign w_sum  = w_base + w_psum_ext;

    // A single-beat group completes on its first (and only) beat.
    assign w_last = (r_state == c_ST_IDLE) ? (IN_GROUPS == 1) : (r_cnt == c_CNT_LAST);

    ofm_sat_clamp #(
        .ACC_BIT (c_ACC_BIT),
        .OFM_BIT (OFM_BIT)
    ) u_clamp (
        .acc_in  (w_sum),
        .ofm_out (w_clamped)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_ST_IDLE;
            r_cnt       <= '0;
            r_acc       <= '0;
            r_out_valid <= 1'b0;
            r_ofm       <= '0;
        end else begin
            r_out_valid <= 1'b0;
            if (in_valid) begin
                if (w_last) begin
                    r_ofm       <= w_clamped;
                    r_out_valid <= 1'b1;
                    r_cnt       <= '0;
                    r_acc       <= '0;
                    r_state     <= c_ST_IDLE;
                end else begin
                    r_acc       <= w_sum;
                    r_cnt       <= r_cnt + c_CNT_W'(1);
                    r_state     <= c_ST_ACCUM;
                end
            end
        end
    end

    assign out_valid = r_out_valid;
    assign OFM       = r_ofm;
    assign busy      = (r_state == c_ST_ACCUM);

endmodule

`default_nettype wire

// File: tb/tb_ofm_accumulator.sv
// ============================================================================
// Module      : tb_ofm_accumulator
// Description : Self-checking bench for ofm_accumulator. Three instances
//               (IN_GROUPS=4/OFM_BIT=29, IN_GROUPS=2/OFM_BIT=8,
//               IN_GROUPS=1/OFM_BIT=29) driven by directed steps followed by
//               random beats, checked every cycle against a group-sum model.
//               Expected clamp behaviour follows OFM_ACC_SAT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ofm_accumulator;

    localparam int c_N0 = 4, c_B0 = 29;
    localparam int c_N1 = 2, c_B1 = 8;
    localparam int c_N2 = 1, c_B2 = 29;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  vld = 3'b000;
    logic [23:0] psum = '0;
    logic [15:0] bias = '0;

    logic        ov0, ov1, ov2;
    logic        bz0, bz1, bz2;
    logic [28:0] ofm0;
    logic [7:0]  ofm1;
    logic [28:0] ofm2;

    int errors = 0;
    int checks = 0;

    int     m_cnt [3];
    longint m_sum [3];
    logic   m_ov  [3];
    longint m_ofm [3];

    always #5 clk = ~clk;

    ofm_accumulator #(.PSUM_BIT(24), .BIAS_BIT(16), .OFM_BIT(c_B0), .IN_GROUPS(c_N0)) u_dut0 (
        .clk(clk), .rst(rst), .in_valid(vld[0]), .psum(psum), .bias(bias),
        .out_valid(ov0), .OFM(ofm0), .busy(bz0));

    ofm_accumulator #(.PSUM_BIT(24), .BIAS_BIT(16), .OFM_BIT(c_B1), .IN_GROUPS(c_N1)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(vld[1]), .psum(psum), .bias(bias),
        .out_valid(ov1), .OFM(ofm1), .busy(bz1));

    ofm_accumulator #(.PSUM_BIT(24), .BIAS_BIT(16), .OFM_BIT(c_B2), .IN_GROUPS(c_N2)) u_dut2 (
        .clk(clk), .rst(rst), .in_valid(vld[2]), .psum(psum), .bias(bias),
        .out_valid(ov2), .OFM(ofm2), .busy(bz2));

    function automatic int groups_of(input int k);
        return (k == 0) ? c_N0 : (k == 1) ? c_N1 : c_N2;
    endfunction

    function automatic int bits_of(input int k);
        return (k == 0) ? c_B0 : (k == 1) ? c_B1 : c_B2;
    endfunction

    function automatic longint clamp(input longint v, input int b);
        longint one;
        longint hi;
        longint lo;
        longint m;
        longint r;
        one = 1;
        hi  = (one <<< (b - 1)) - 1;
        lo  = -hi - 1;
        m   = one <<< b;
`ifdef OFM_ACC_SAT_EN
        r = (v > hi) ? hi : (v < lo) ? lo : v;
`else
        r = v % m;
        if (r < 0) r = r + m;
        if (r > hi) r = r - m;
`endif
        return r;
    endfunction

    function automatic longint act_ofm(input int k);
        longint r;
        case (k)
            0:       r = longint'($signed(ofm0));
            1:       r = longint'($signed(ofm1));
            default: r = longint'($signed(ofm2));
        endcase
        return r;
    endfunction

    function automatic longint act_ov(input int k);
        return (k == 0) ? longint'(ov0) : (k == 1) ? longint'(ov1) : longint'(ov2);
    endfunction

    function automatic longint act_busy(input int k);
        return (k == 0) ? longint'(bz0) : (k == 1) ? longint'(bz1) : longint'(bz2);
    endfunction

    task automatic chk(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Group-level reference: a group is the first beat's bias plus the sum of
    // its IN_GROUPS partial sums; the result appears the cycle after the last beat.
    task automatic model_edge();
        for (int k = 0; k < 3; k++) begin
            if (rst) begin
                m_cnt[k] = 0;
                m_sum[k] = 0;
                m_ov[k]  = 1'b0;
                m_ofm[k] = 0;
            end else begin
                m_ov[k] = 1'b0;
                if (vld[k]) begin
                    if (m_cnt[k] == 0)
                        m_sum[k] = longint'($signed(bias)) + longint'($signed(psum));
                    else
                        m_sum[k] = m_sum[k] + longint'($signed(psum));
                    m_cnt[k] = m_cnt[k] + 1;
                    if (m_cnt[k] == groups_of(k)) begin
                        m_ov[k]  = 1'b1;
                        m_ofm[k] = clamp(m_sum[k], bits_of(k));
                        m_cnt[k] = 0;
                    end
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("out_valid%0d", k), act_ov(k), longint'(m_ov[k]));
            chk($sformatf("OFM%0d", k), act_ofm(k), m_ofm[k]);
            chk($sformatf("busy%0d", k), act_busy(k), longint'(m_cnt[k] != 0));
        end
    endtask

    task automatic step(input logic [2:0] v, input longint p, input longint b, input logic r);
        vld  = v;
        psum = 24'(p);
        bias = 16'(b);
        rst  = r;
        tick();
    endtask

    initial begin
        // Reset
        step(3'b000, 0, 0, 1'b1);
        step(3'b000, 0, 0, 1'b1);
        chk("reset_ov0", longint'(ov0), 0);
        chk("reset_ofm0", act_ofm(0), 0);
        chk("reset_busy0", longint'(bz0), 0);

        // bias 10, psums 1..4 back-to-back -> 20
        step(3'b001, 1, 10, 1'b0);
        chk("busy_after_first", longint'(bz0), 1);
        step(3'b001, 2, 99, 1'b0);
        step(3'b001, 3, 99, 1'b0);
        step(3'b001, 4, 99, 1'b0);
        chk("plan_back2back_ov", longint'(ov0), 1);
        chk("plan_back2back_ofm", act_ofm(0), 20);
        chk("plan_back2back_busy", longint'(bz0), 0);
        step(3'b000, 0, 0, 1'b0);
        chk("pulse_one_cycle", longint'(ov0), 0);
        chk("ofm_holds", act_ofm(0), 20);

        // same beats with 2-cycle gaps
        for (int i = 1; i <= 4; i++) begin
            step(3'b001, i, (i == 1) ? 10 : -500, 1'b0);
            if (i < 4) begin
                step(3'b000, 0, 0, 1'b0);
                step(3'b000, 0, 0, 1'b0);
            end
        end
        chk("plan_gaps_ofm", act_ofm(0), 20);
        chk("plan_gaps_ov", longint'(ov0), 1);

        // back-to-back groups: bias 5 then -7, psums all 1 -> 9 then -3
        for (int i = 0; i < 8; i++)
            step(3'b001, 1, (i < 4) ? 5 : -7, 1'b0);
        chk("plan_b2b_group2_ofm", act_ofm(0), -3);
        step(3'b000, 0, 0, 1'b0);

        // OFM_BIT=8 clamp/wrap
        step(3'b010, 100, 0, 1'b0);
        step(3'b010, 100, 0, 1'b0);
`ifdef OFM_ACC_SAT_EN
        chk("plan_pos_clamp", act_ofm(1), 127);
`else
        chk("plan_pos_wrap", act_ofm(1), -56);
`endif
        step(3'b010, -100, 0, 1'b0);
        step(3'b010, -100, 0, 1'b0);
`ifdef OFM_ACC_SAT_EN
        chk("plan_neg_clamp", act_ofm(1), -128);
`else
        chk("plan_neg_wrap", act_ofm(1), 56);
`endif

        // IN_GROUPS=1: every beat produces a result
        for (int i = 0; i < 3; i++) begin
            step(3'b100, 1, -3, 1'b0);
            chk("plan_g1_ov", longint'(ov2), 1);
            chk("plan_g1_ofm", act_ofm(2), -2);
            chk("plan_g1_busy", longint'(bz2), 0);
        end
        step(3'b000, 0, 0, 1'b0);

        // reset mid-group, then a clean group of 4 x 1 -> 4
        step(3'b001, 50, 50, 1'b0);
        step(3'b001, 50, 50, 1'b0);
        step(3'b000, 0, 0, 1'b1);
        for (int i = 0; i < 4; i++)
            step(3'b001, 1, 0, 1'b0);
        chk("plan_rst_mid_ofm", act_ofm(0), 4);
        chk("plan_rst_mid_ov", longint'(ov0), 1);

        // reset coinciding with the final beat drops the result
        for (int i = 0; i < 3; i++)
            step(3'b001, 7, 0, 1'b0);
        step(3'b001, 7, 0, 1'b1);
        chk("plan_rst_final_ov", longint'(ov0), 0);
        chk("plan_rst_final_ofm", act_ofm(0), 0);
        step(3'b000, 0, 0, 1'b0);

        // random traffic on all instances
        for (int i = 0; i < 600; i++) begin
            step(3'($urandom), longint'($signed(24'($urandom))),
                 longint'($signed(16'($urandom))), ($urandom_range(0, 63) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ofm_accumulator.md
# ofm_accumulator

Accumulates a stream of signed partial sums into one output-feature-map value per output pixel/channel, adds the fused (batch-norm folded) bias, clamps to OFM_BIT and emits it with a one-cycle valid pulse. Sits between the convolution MAC array and the quantize/ReLU activation stage. It is the producer side of the activation stage's in_valid/OFM interface: OFM is two's-complement, valid for exactly the cycle out_valid is high, with no backpressure.

## Interface
- PSUM_BIT, 24: width of signed partial sum from MAC array
- BIAS_BIT, 16: width of signed fused bias
- OFM_BIT, 29: width of signed OFM output (per-layer values 21..29)
- IN_GROUPS, 64: partial sums per output value (≥1)
- clk  input  1  single clock, all logic on rising edge
- rst  input  1  reset; synchronous and active-high
- in_valid  input  1  psum (and bias on first beat) valid this cycle
- psum  input  PSUM_BIT  signed partial sum
- bias  input  BIAS_BIT  signed bias; sampled only on first beat of a group
- out_valid  output  1  one-cycle pulse, OFM valid
- OFM  output  OFM_BIT  signed accumulated result
- busy  output  1  high while a group is partially accumulated

## Operation
- Internal accumulator ACC_BIT = max(PSUM_BIT, BIAS_BIT) + clog2(IN_GROUPS) + 1, signed; never overflows internally.
- Beat counter cnt, 0..IN_GROUPS-1; advances only on in_valid; gaps (in_valid low) hold cnt and acc unchanged.
- FSM: IDLE (cnt=0, busy=0) and ACCUM (cnt>0, busy=1).
  - IDLE + in_valid: acc ← sext(bias) + sext(psum); cnt ← 1; go ACCUM. If IN_GROUPS=1, instead finish immediately (stay IDLE).
  - ACCUM + in_valid, cnt<IN_GROUPS-1: acc ← acc + sext(psum); cnt++.
  - ACCUM + in_valid, cnt=IN_GROUPS-1: final = acc + sext(psum); register OFM ← clamp(final); out_valid ← 1; cnt ← 0; go IDLE.
  - No in_valid: state held.
- Back-to-back groups: a beat in the cycle after the final beat starts the next group (bias sampled again); no bubble required.
- out_valid low in every cycle not following a final beat; OFM holds last emitted value when out_valid is low.
- Bias ignored on non-first beats.

## Timing
- Reset values: out_valid=0, OFM=0, busy=0; cnt=0, acc=0, state IDLE.
- Latency: out_valid rises the cycle after the final beat's in_valid edge; throughput one OFM per IN_GROUPS beats.
- busy rises the cycle after the first beat, falls the cycle after the final beat (same edge out_valid rises).
- Reset mid-group: partial sum discarded, cnt=0; if asserted in the cycle of a final beat, that result is dropped (out_valid stays 0). rst and in_valid together: rst wins.

## Configuration
- OFM_ACC_SAT_EN defined: clamp(final) saturates to [-2^(OFM_BIT-1), 2^(OFM_BIT-1)-1].
- Undefined: clamp(final) = low OFM_BIT bits of final (two's-complement wrap); fewer gates, valid when layer bounds guarantee no overflow.

## Structure
- Shared package: clog2 function, ACC_BIT derivation, default PSUM_BIT/BIAS_BIT/OFM_BIT constants, per-layer OFM_BIT list for VGG-16.
- One sub-module natural: ofm_sat_clamp (ACC_BIT→OFM_BIT clamp/wrap, combinational, macro-controlled).
- Counter, FSM, accumulator and output register in top.

## Test plan
- IN_GROUPS=4, bias=10, psums 1,2,3,4 back-to-back → one cycle later out_valid=1, OFM=20; busy high 3 cycles.
- IN_GROUPS=4, same beats with 2-cycle gaps between each → OFM=20, out_valid exactly one cycle, no early pulse.
- Two groups back-to-back (bias 5 then -7, psums all 1) → OFM=9 then OFM=-3, pulses 4 cycles apart.
- OFM_BIT=8, IN_GROUPS=2, bias=0, psums 100,100 → with OFM_ACC_SAT_EN OFM=127; without OFM=-56. psums -100,-100 → -128 / 56.
- IN_GROUPS=1, bias=-3, psum=1 each cycle for 3 cycles → out_valid high 3 consecutive cycles, OFM=-2.
- IN_GROUPS=4, rst after 2 beats, then 4 beats of psum=1, bias=0 → single OFM=4, no output from aborted group; rst on final-beat cycle → no pulse.
